score_tracker: RTL and testbench

SCORE_TRACKER -- requirements
Module: score_tracker

---
 rtl/score_tracker.sv | 125 ++++++++++++
 tb/tb_score_tracker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/score_tracker.sv
// Game score keeper: BCD score with edge-detected points, saturation at 9999,
// and a high score that survives game restarts (only clr clears it).
module score_tracker (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        plusone,
    input  logic        game_over,
    input  logic        game_rst,
    input  logic        show_hi,
    output logic [15:0] score,
    output logic [15:0] hiscore,
    output logic [15:0] disp,
    output logic        new_record,
    output logic        sat,
    output logic [1:0]  st
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PLAYING = 2'b01,
        UPDATE  = 2'b10,
        OVER    = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_score;
    logic [15:0] r_hi;
    logic        r_nr;
    logic        r_plus_q;
    logic        w_rise;
    logic        w_sat;
    logic        w_clear;
    logic        w_inc;
    logic        w_upd_hi;
    logic [15:0] w_score_inc;

    // Ripple-carry BCD increment; a digit only rolls 9->0 when all lower digits carry.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        c;
        res = v;
        c   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    res[i*4 +: 4] = 4'd0;
                end else begin
                    res[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c             = 1'b0;
                end
            end
        end
        return res;
    endfunction

    assign w_rise      = plusone & ~r_plus_q;
    assign w_sat       = (r_score == 16'h9999);
    assign w_score_inc = bcd_inc(r_score);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_inc    = 1'b0;
        w_upd_hi = 1'b0;
        if (game_rst) begin
            w_next  = IDLE;
            w_clear = 1'b1;
        end else begin
            case (r_state)
                IDLE, OVER: begin
                    if (start) begin
                        w_next  = PLAYING;
                        w_clear = 1'b1;
                    end
                end
                PLAYING: begin
                    // game_over wins over a simultaneous point
                    if (game_over) w_next = UPDATE;
                    else           w_inc  = w_rise & ~w_sat;
                end
                UPDATE: begin
                    w_next   = OVER;
                    w_upd_hi = (r_score > r_hi);
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_score  <= 16'h0000;
            r_hi     <= 16'h0000;
            r_nr     <= 1'b0;
            r_plus_q <= 1'b0;
        end else begin
            r_plus_q <= plusone;
            if (w_clear) begin
                r_score <= 16'h0000;
                r_nr    <= 1'b0;
            end else if (w_inc) begin
                r_score <= w_score_inc;
            end
            if (w_upd_hi) begin
                r_hi <= r_score;
                r_nr <= 1'b1;
            end
        end
    end

    assign score      = r_score;
    assign hiscore    = r_hi;
    assign new_record = r_nr;
    assign sat        = w_sat;
    assign st         = r_state;
    assign disp       = show_hi ? r_hi : r_score;

endmodule

// File: tb/tb_score_tracker.sv
// Randomized and directed bench for score_tracker against an integer-valued game model.
module tb_score_tracker;

    logic        clk = 1'b0;
    logic        clr, start, plusone, game_over, game_rst, show_hi;
    logic [15:0] score, hiscore, disp;
    logic        new_record, sat;
    logic [1:0]  st;

    int checks = 0;
    int errors = 0;

    // reference model: plain integers, state by spec code
    int m_st, m_score, m_hi, m_nr, m_prev;

    score_tracker dut (
        .clk(clk), .clr(clr), .start(start), .plusone(plusone),
        .game_over(game_over), .game_rst(game_rst), .show_hi(show_hi),
        .score(score), .hiscore(hiscore), .disp(disp),
        .new_record(new_record), .sat(sat), .st(st)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic model_reset();
        m_st = 0; m_score = 0; m_hi = 0; m_nr = 0; m_prev = 0;
    endtask

    // One clock: drive on negedge, advance model at posedge, return 1ns after it.
    task automatic tick(input logic s, input logic p, input logic g, input logic r);
        @(negedge clk);
        start = s; plusone = p; game_over = g; game_rst = r;
        @(posedge clk);
        if (r) begin
            m_st = 0; m_score = 0; m_nr = 0;
        end else begin
            case (m_st)
                0, 3: if (s) begin m_st = 1; m_score = 0; m_nr = 0; end
                1: begin
                    if (g) m_st = 2;
                    else if (p && !m_prev && m_score < 9999) m_score++;
                end
                default: begin
                    if (m_score > m_hi) begin m_hi = m_score; m_nr = 1; end
                    m_st = 3;
                end
            endcase
        end
        m_prev = p;
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick(0, 1, 0, 0);
            tick(0, 0, 0, 0);
        end
    endtask

    task automatic new_game();
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
    endtask

    task automatic test_reset();
        clr = 1'b0; start = 0; plusone = 0; game_over = 0; game_rst = 0; show_hi = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (st !== 2'b00)        begin errors++; $display("FAIL reset_st got %b want 00", st); end
        checks++; if (score !== 16'h0000)  begin errors++; $display("FAIL reset_score got %h want 0000", score); end
        checks++; if (hiscore !== 16'h0000) begin errors++; $display("FAIL reset_hi got %h want 0000", hiscore); end
        checks++; if (new_record !== 1'b0 || sat !== 1'b0 || disp !== 16'h0000)
            begin errors++; $display("FAIL reset_misc got nr=%b sat=%b disp=%h want 0 0 0000", new_record, sat, disp); end
        @(negedge clk); clr = 1'b1;
    endtask

    task automatic test_pulses();
        tick(1, 0, 0, 0);
        checks++; if (st !== 2'b01) begin errors++; $display("FAIL start_st got %b want 01", st); end
        tick(0, 1, 0, 0); tick(0, 0, 0, 0);
        repeat (5)  tick(0, 1, 0, 0); tick(0, 0, 0, 0);
        repeat (40) tick(0, 1, 0, 0); tick(0, 0, 0, 0);
        checks++; if (score !== 16'h0003 || st !== 2'b01)
            begin errors++; $display("FAIL held_pulses got score=%h st=%b want 0003 01", score, st); end
    endtask

    task automatic test_carry();
        new_game(); pulses(9);
        checks++; if (score !== 16'h0009) begin errors++; $display("FAIL pre9 got %h want 0009", score); end
        pulses(1);
        checks++; if (score !== 16'h0010) begin errors++; $display("FAIL carry10 got %h want 0010", score); end
        new_game(); pulses(999);
        checks++; if (score !== 16'h0999) begin errors++; $display("FAIL pre999 got %h want 0999", score); end
        pulses(1);
        checks++; if (score !== 16'h1000) begin errors++; $display("FAIL carry1000 got %h want 1000", score); end
        new_game(); pulses(9999);
        checks++; if (score !== 16'h9999 || sat !== 1'b1)
            begin errors++; $display("FAIL pre9999 got %h sat=%b want 9999 1", score, sat); end
        pulses(1);
        checks++; if (score !== 16'h9999 || sat !== 1'b1)
            begin errors++; $display("FAIL saturate got %h sat=%b want 9999 1", score, sat); end
    endtask

    task automatic test_game_over();
        new_game(); pulses(42);
        tick(0, 0, 1, 0);
        checks++; if (st !== 2'b10 || hiscore !== 16'h0000)
            begin errors++; $display("FAIL update_st got st=%b hi=%h want 10 0000", st, hiscore); end
        tick(0, 0, 0, 0);
        checks++; if (st !== 2'b11 || hiscore !== 16'h0042 || new_record !== 1'b1)
            begin errors++; $display("FAIL over_hi got st=%b hi=%h nr=%b want 11 0042 1", st, hiscore, new_record); end
        pulses(3);
        checks++; if (score !== 16'h0042 || st !== 2'b11)
            begin errors++; $display("FAIL over_frozen got score=%h st=%b want 0042 11", score, st); end
    endtask

    task automatic test_second_game();
        tick(1, 0, 0, 0);
        checks++; if (st !== 2'b01 || score !== 16'h0000 || new_record !== 1'b0 || hiscore !== 16'h0042)
            begin errors++; $display("FAIL restart got st=%b sc=%h nr=%b hi=%h want 01 0000 0 0042", st, score, new_record, hiscore); end
        pulses(17); tick(0, 0, 1, 0); tick(0, 0, 0, 0);
        checks++; if (hiscore !== 16'h0042 || new_record !== 1'b0 || st !== 2'b11)
            begin errors++; $display("FAIL no_record got hi=%h nr=%b st=%b want 0042 0 11", hiscore, new_record, st); end
        show_hi = 1'b1; #1;
        checks++; if (disp !== 16'h0042) begin errors++; $display("FAIL disp_hi got %h want 0042", disp); end
        show_hi = 1'b0; #1;
        checks++; if (disp !== 16'h0017) begin errors++; $display("FAIL disp_score got %h want 0017", disp); end
    endtask

    task automatic test_collision();
        new_game(); pulses(5);
        tick(0, 1, 1, 0);
        checks++; if (score !== 16'h0005 || st !== 2'b10)
            begin errors++; $display("FAIL go_drop got score=%h st=%b want 0005 10", score, st); end
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 1);
        checks++; if (st !== 2'b00 || score !== 16'h0000 || hiscore !== 16'h0042 || new_record !== 1'b0)
            begin errors++; $display("FAIL rst_prio got st=%b sc=%h hi=%h nr=%b want 00 0000 0042 0", st, score, hiscore, new_record); end
    endtask

    task automatic test_clr_mid();
        new_game(); pulses(123);
        checks++; if (score !== 16'h0123) begin errors++; $display("FAIL pre123 got %h want 0123", score); end
        #2 clr = 1'b0; plusone = 1'b1; show_hi = 1'b1;
        #1;
        model_reset();
        checks++; if (st !== 2'b00 || score !== 16'h0000 || hiscore !== 16'h0000 ||
                      new_record !== 1'b0 || sat !== 1'b0 || disp !== 16'h0000)
            begin errors++; $display("FAIL async_clr got st=%b sc=%h hi=%h nr=%b sat=%b disp=%h want all 0", st, score, hiscore, new_record, sat, disp); end
        show_hi = 1'b0;
        @(negedge clk); clr = 1'b1;
        tick(1, 1, 0, 0);
        repeat (3) tick(0, 1, 0, 0);
        checks++; if (score !== 16'h0000 || st !== 2'b01)
            begin errors++; $display("FAIL held_at_release got %h st=%b want 0000 01", score, st); end
        tick(0, 0, 0, 0); tick(0, 1, 0, 0);
        checks++; if (score !== 16'h0001) begin errors++; $display("FAIL rerise got %h want 0001", score); end
    endtask

    task automatic test_random();
        logic s, p, g, r;
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 9) == 0);
            p = $urandom_range(0, 1);
            g = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 59) == 0);
            show_hi = $urandom_range(0, 1);
            tick(s, p, g, r);
            checks++;
            if (st !== 2'(m_st) || score !== to_bcd(m_score) || hiscore !== to_bcd(m_hi) ||
                new_record !== 1'(m_nr) || sat !== (m_score == 9999) ||
                disp !== (show_hi ? to_bcd(m_hi) : to_bcd(m_score))) begin
                errors++;
                $display("FAIL random[%0d] got st=%b sc=%h hi=%h nr=%b disp=%h want st=%0d sc=%h hi=%h nr=%0d",
                         i, st, score, hiscore, new_record, disp, m_st, to_bcd(m_score), to_bcd(m_hi), m_nr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pulses();
        test_carry();
        test_game_over();
        test_second_game();
        test_collision();
        test_clr_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
